// File: rtl/ex_flag_if.sv
// EX-to-EX/MEM handshake bundle for the flag stage: pipeline control, adder inputs,
// registered results, the architectural flags and the branch decision.
interface ex_flag_if #(
   parameter int unsigned DW = 16,
   parameter int unsigned RW = 4
);
   localparam int unsigned OPW = 3;

   logic           stall;
   logic           flush;
   logic           in_valid;
   logic [OPW-1:0] in_op;
   logic [DW-1:0]  in_s;
   logic           in_n;
   logic           in_v;
   logic           in_z;
   logic [RW-1:0]  in_rd;
   logic           in_wen;
   logic           in_branch;
   logic [OPW-1:0] in_cond;
   logic           out_valid;
   logic [DW-1:0]  out_result;
   logic [RW-1:0]  out_rd;
   logic           out_wen;
   logic           flag_n;
   logic           flag_v;
   logic           flag_z;
   logic           br_taken;
   logic           br_valid;

   modport master (
      output stall, flush, in_valid, in_op, in_s, in_n, in_v, in_z,
             in_rd, in_wen, in_branch, in_cond,
      input  out_valid, out_result, out_rd, out_wen,
             flag_n, flag_v, flag_z, br_taken, br_valid
   );

   modport slave (
      input  stall, flush, in_valid, in_op, in_s, in_n, in_v, in_z,
             in_rd, in_wen, in_branch, in_cond,
      output out_valid, out_result, out_rd, out_wen,
             flag_n, flag_v, flag_z, br_taken, br_valid
   );
endinterface

// File: rtl/ex_flag_stage.sv
// EX post-adder stage: signed saturation, N/V/Z flag register with per-op masks,
// branch evaluation on the pre-edge flags, and the EX/MEM register with stall/flush.
module ex_flag_stage #(
   parameter int unsigned DW = 16,
   parameter int unsigned RW = 4
) (
   input logic        clk,
   input logic        rst,
   ex_flag_if.slave   bus
);
   localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

   logic          arith_c;
   logic          zonly_c;
   logic          cond_c;
   logic [DW-1:0] result_c;

   // Branches ignore in_op, so they never saturate and never touch the flags
   assign arith_c = (bus.in_op[2:1] == 2'b00) && !bus.in_branch;
   assign zonly_c = (bus.in_op[2:1] == 2'b01) && !bus.in_branch;

   always_comb begin
      result_c = bus.in_s;
      if (arith_c && bus.in_v) begin
         result_c = bus.in_s[DW-1] ? SAT_MAX : SAT_MIN;
      end
   end

   always_comb begin
      cond_c = 1'b0;
      case (bus.in_cond)
         3'b000:  cond_c = !bus.flag_z;
         3'b001:  cond_c = bus.flag_z;
         3'b010:  cond_c = !bus.flag_z && !bus.flag_n;
         3'b011:  cond_c = bus.flag_n;
         3'b100:  cond_c = bus.flag_z || !bus.flag_n;
         3'b101:  cond_c = bus.flag_n || bus.flag_z;
         3'b110:  cond_c = bus.flag_v;
         default: cond_c = 1'b1;
      endcase
   end

   // Flush beats stall; a bubble clears the valids but keeps result/rd
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid  <= 1'b0;
         bus.out_result <= '0;
         bus.out_rd     <= '0;
         bus.out_wen    <= 1'b0;
         bus.flag_n     <= 1'b0;
         bus.flag_v     <= 1'b0;
         bus.flag_z     <= 1'b0;
         bus.br_taken   <= 1'b0;
         bus.br_valid   <= 1'b0;
      end else if (bus.flush) begin
         bus.out_valid <= 1'b0;
         bus.out_wen   <= 1'b0;
         bus.br_valid  <= 1'b0;
         bus.br_taken  <= 1'b0;
      end else if (!bus.stall) begin
         if (bus.in_valid) begin
            bus.out_valid  <= 1'b1;
            bus.out_wen    <= bus.in_wen && !bus.in_branch;
            bus.out_result <= result_c;
            bus.out_rd     <= bus.in_rd;
            bus.br_valid   <= bus.in_branch;
            bus.br_taken   <= bus.in_branch && cond_c;
            if (arith_c) begin
               bus.flag_n <= result_c[DW-1];
               bus.flag_v <= bus.in_v;
            end
            if (arith_c || zonly_c) begin
               bus.flag_z <= (result_c == '0);
            end
         end else begin
            bus.out_valid <= 1'b0;
            bus.out_wen   <= 1'b0;
            bus.br_valid  <= 1'b0;
            bus.br_taken  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ex_flag_stage.sv
// Bench for ex_flag_stage: directed scenarios followed by random traffic, all
// compared against a behavioural model of the stage's architectural rules.
module tb_ex_flag_stage;
   localparam int unsigned DW = 16;
   localparam int unsigned RW = 4;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   ex_flag_if #(.DW(DW), .RW(RW)) bus ();

   ex_flag_stage #(.DW(DW), .RW(RW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference state
   logic          m_valid, m_wen, m_n, m_v, m_z, m_brt, m_brv;
   logic [DW-1:0] m_result;
   logic [RW-1:0] m_rd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_wen = 0; m_n = 0; m_v = 0; m_z = 0;
      m_brt = 0; m_brv = 0; m_result = '0; m_rd = '0;
   endtask

   function automatic logic cond_holds(input logic [2:0] c, input logic n, input logic v,
                                       input logic z);
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || !n;
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   // What the architecture says one clock edge does to the EX/MEM state
   task automatic model_edge();
      logic [DW-1:0] r;
      if (rst) begin
         model_reset();
      end else if (bus.flush) begin
         m_valid = 0; m_wen = 0; m_brv = 0; m_brt = 0;
      end else if (bus.stall) begin
         // everything holds
      end else if (!bus.in_valid) begin
         m_valid = 0; m_wen = 0; m_brv = 0; m_brt = 0;
      end else begin
         r = bus.in_s;
         if (!bus.in_branch && bus.in_op <= 3'd1 && bus.in_v)
            r = bus.in_s[DW-1] ? 16'h7FFF : 16'h8000;
         m_valid  = 1;
         m_wen    = bus.in_wen && !bus.in_branch;
         m_result = r;
         m_rd     = bus.in_rd;
         if (bus.in_branch) begin
            m_brv = 1;
            m_brt = cond_holds(bus.in_cond, m_n, m_v, m_z);
         end else begin
            m_brv = 0;
            m_brt = 0;
            if (bus.in_op <= 3'd1) begin
               m_n = r[DW-1];
               m_v = bus.in_v;
               m_z = (r == 0);
            end else if (bus.in_op <= 3'd3) begin
               m_z = (r == 0);
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".valid"},  32'(bus.out_valid),  32'(m_valid));
      check({tag, ".result"}, 32'(bus.out_result), 32'(m_result));
      check({tag, ".rd"},     32'(bus.out_rd),     32'(m_rd));
      check({tag, ".wen"},    32'(bus.out_wen),    32'(m_wen));
      check({tag, ".nvz"},    32'({bus.flag_n, bus.flag_v, bus.flag_z}), 32'({m_n, m_v, m_z}));
      check({tag, ".br"},     32'({bus.br_valid, bus.br_taken}), 32'({m_brv, m_brt}));
   endtask

   task automatic drive(input logic valid, input logic [2:0] op, input logic [DW-1:0] s,
                        input logic v, input logic [RW-1:0] rd, input logic wen,
                        input logic br, input logic [2:0] cond, input logic stall,
                        input logic flush);
      bus.in_valid = valid; bus.in_op = op; bus.in_s = s; bus.in_v = v;
      bus.in_n = s[DW-1]; bus.in_z = (s == 0); bus.in_rd = rd; bus.in_wen = wen;
      bus.in_branch = br; bus.in_cond = cond; bus.stall = stall; bus.flush = flush;
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      model_reset();
      rst = 1'b1;
      drive(0, 3'd0, 16'h0, 0, 4'd0, 0, 0, 3'd0, 0, 0);
      cycle("in_reset");
      cycle("in_reset2");
      @(negedge clk);
      rst = 1'b0;
      cycle("idle");
      check("idle_valid", 32'(bus.out_valid), 32'd0);

      // positive overflow saturates to max positive
      drive(1, 3'd0, 16'h8001, 1, 4'd3, 1, 0, 3'd0, 0, 0);
      cycle("pos_ovf");
      check("pos_ovf_result", 32'(bus.out_result), 32'h7FFF);
      check("pos_ovf_rd", 32'(bus.out_rd), 32'd3);
      check("pos_ovf_nvz", 32'({bus.flag_n, bus.flag_v, bus.flag_z}), 32'b010);

      // async reset between edges with non-zero outputs
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      cycle("rst_held");
      @(negedge clk);
      rst = 1'b0;

      // negative overflow then XOR zero keeping N and V
      drive(1, 3'd1, 16'h7FFF, 1, 4'd5, 1, 0, 3'd0, 0, 0);
      cycle("neg_ovf");
      check("neg_ovf_result", 32'(bus.out_result), 32'h8000);
      drive(1, 3'd2, 16'h0000, 0, 4'd6, 1, 0, 3'd0, 0, 0);
      cycle("xor_zero");
      check("xor_zero_nvz", 32'({bus.flag_n, bus.flag_v, bus.flag_z}), 32'b111);

      // branch right after a flag setter
      drive(1, 3'd1, 16'h0000, 0, 4'd1, 1, 0, 3'd0, 0, 0);
      cycle("sub_zero");
      drive(1, 3'd0, 16'h0042, 0, 4'd2, 1, 1, 3'd1, 0, 0);
      cycle("br_eq");
      check("br_eq_taken", 32'({bus.br_valid, bus.br_taken}), 32'b11);
      drive(1, 3'd0, 16'h0042, 0, 4'd2, 1, 1, 3'd0, 0, 0);
      cycle("br_ne");
      check("br_ne_taken", 32'({bus.br_valid, bus.br_taken}), 32'b10);
      drive(1, 3'd0, 16'h0042, 0, 4'd2, 1, 1, 3'd7, 0, 0);
      cycle("br_always");
      check("br_always_taken", 32'(bus.br_taken), 32'd1);

      // stall holds everything for three cycles
      drive(1, 3'd0, 16'h1234, 0, 4'd9, 1, 0, 3'd0, 1, 0);
      for (int i = 0; i < 3; i++) cycle("stall");
      check("stall_result", 32'(bus.out_result), 32'h0042);
      drive(1, 3'd0, 16'h1234, 0, 4'd9, 1, 0, 3'd0, 0, 0);
      cycle("unstall");
      check("unstall_result", 32'(bus.out_result), 32'h1234);

      // flush with stall squashes the would-be zero result
      drive(1, 3'd0, 16'h0000, 0, 4'd4, 1, 0, 3'd0, 1, 1);
      cycle("flush");
      check("flush_valid_wen", 32'({bus.out_valid, bus.out_wen}), 32'b00);
      check("flush_z", 32'(bus.flag_z), 32'd0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic [DW-1:0] s;
         int sel;
         sel = int'($urandom_range(0, 7));
         s = (sel == 0) ? 16'h0000 : DW'($urandom);
         drive(1'($urandom_range(0, 3) != 0), 3'($urandom), s, 1'($urandom),
               RW'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
               3'($urandom), 1'($urandom_range(0, 5) == 0),
               1'($urandom_range(0, 7) == 0));
         cycle("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
